// File: rtl/core_pkg.sv
// Shared MIPS core definitions: default datapath widths, ALU opcodes, register zero.
// No logic, no latency.
// No handshake; constants only.
package core_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_ALUC_W = 4;

    localparam logic [DEF_ALUC_W-1:0] ALU_AND = 4'h0;
    localparam logic [DEF_ALUC_W-1:0] ALU_OR  = 4'h1;
    localparam logic [DEF_ALUC_W-1:0] ALU_ADD = 4'h2;
    localparam logic [DEF_ALUC_W-1:0] ALU_SUB = 4'h6;
    localparam logic [DEF_ALUC_W-1:0] ALU_SLT = 4'h7;
    localparam logic [DEF_ALUC_W-1:0] ALU_NOR = 4'hC;

    localparam logic [DEF_REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect_lu.sv
// Load-use hazard detector: ID instruction reads the register an EXE load is producing.
// Purely combinational, zero latency.
// No handshake; the caller decides how stalls and flushes gate the result.
module hazard_detect_lu
    import core_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rt,
    input  logic             valid_execute,
    input  logic             mem_to_reg_execute,
    input  logic [REG_W-1:0] reg_dest_execute,
    output logic             hz
);

    logic dest_live;
    logic src_match;

    // Writes to $zero are discarded, so a load targeting it can never be a dependency.
    assign dest_live = valid_execute & mem_to_reg_execute &
                       (reg_dest_execute != REG_W'(REG_ZERO));
    assign src_match = (rs == reg_dest_execute) | (use_rt & (rt == reg_dest_execute));
    assign hz        = id_valid & dest_live & src_match;

endmodule

// File: rtl/idexe_pipe_reg.sv
// ID/EXE pipeline register with valid bit, flush-to-bubble and load-use bubble insertion.
// One cycle from ID inputs to EXE outputs.
// stall_in holds every EXE register; load_use_stall tells PC and IF/ID to hold.
module idexe_pipe_reg
    import core_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int ALUC_W = DEF_ALUC_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              write_reg,
    input  logic              write_mem,
    input  logic              mem_to_reg,
    input  logic [ALUC_W-1:0] alu_control,
    input  logic              alu_immediate,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic              use_rt,
    input  logic [REG_W-1:0]  reg_dest,
    input  logic [DATA_W-1:0] qa,
    input  logic [DATA_W-1:0] qb,
    input  logic [DATA_W-1:0] immediate_32,
    output logic              valid_execute,
    output logic              write_reg_execute,
    output logic              write_mem_execute,
    output logic              mem_to_reg_execute,
    output logic              alu_immediate_execute,
    output logic [ALUC_W-1:0] alu_control_execute,
    output logic [REG_W-1:0]  reg_dest_execute,
    output logic [DATA_W-1:0] qa_execute,
    output logic [DATA_W-1:0] qb_execute,
    output logic [DATA_W-1:0] immediate_32_execute,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef struct packed {
        logic              valid;
        logic              write_reg;
        logic              write_mem;
        logic              mem_to_reg;
        logic              alu_immediate;
        logic [ALUC_W-1:0] alu_control;
        logic [REG_W-1:0]  reg_dest;
        logic [DATA_W-1:0] qa;
        logic [DATA_W-1:0] qb;
        logic [DATA_W-1:0] imm;
    } ex_t;

    ex_t              ex_q;
    ex_t              ex_d;
    logic             hz;
    logic [CNT_W-1:0] cnt_q;

    hazard_detect_lu #(
        .REG_W (REG_W)
    ) u_hazard (
        .id_valid           (id_valid),
        .rs                 (rs),
        .rt                 (rt),
        .use_rt             (use_rt),
        .valid_execute      (ex_q.valid),
        .mem_to_reg_execute (ex_q.mem_to_reg),
        .reg_dest_execute   (ex_q.reg_dest),
        .hz                 (hz)
    );

    assign load_use_stall = hz & ~flush;

    // A non-valid slot keeps its fields but must never write architectural state.
    always_comb begin
        ex_d               = '0;
        ex_d.valid         = id_valid;
        ex_d.write_reg     = write_reg  & id_valid;
        ex_d.write_mem     = write_mem  & id_valid;
        ex_d.mem_to_reg    = mem_to_reg & id_valid;
        ex_d.alu_immediate = alu_immediate;
        ex_d.alu_control   = alu_control;
        ex_d.reg_dest      = reg_dest;
        ex_d.qa            = qa;
        ex_d.qb            = qb;
        ex_d.imm           = immediate_32;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (stall_in) begin
            ex_q <= ex_q;
        end else if (hz) begin
            ex_q <= '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            ex_q <= ex_d;
        end
    end

    assign valid_execute         = ex_q.valid;
    assign write_reg_execute     = ex_q.write_reg;
    assign write_mem_execute     = ex_q.write_mem;
    assign mem_to_reg_execute    = ex_q.mem_to_reg;
    assign alu_immediate_execute = ex_q.alu_immediate;
    assign alu_control_execute   = ex_q.alu_control;
    assign reg_dest_execute      = ex_q.reg_dest;
    assign qa_execute            = ex_q.qa;
    assign qb_execute            = ex_q.qb;
    assign immediate_32_execute  = ex_q.imm;
    assign bubble_count          = cnt_q;

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Directed bench for idexe_pipe_reg (CNT_W=2 so saturation is reachable).
module tb_idexe_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush, id_valid;
    logic        write_reg, write_mem, mem_to_reg, alu_immediate, use_rt;
    logic [3:0]  alu_control;
    logic [4:0]  rs, rt, reg_dest;
    logic [31:0] qa, qb, immediate_32;
    logic        valid_execute, write_reg_execute, write_mem_execute;
    logic        mem_to_reg_execute, alu_immediate_execute, load_use_stall;
    logic [3:0]  alu_control_execute;
    logic [4:0]  reg_dest_execute;
    logic [31:0] qa_execute, qb_execute, immediate_32_execute;
    logic [1:0]  bubble_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    idexe_pipe_reg #(.DATA_W(32), .REG_W(5), .ALUC_W(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush),
        .id_valid(id_valid), .write_reg(write_reg), .write_mem(write_mem),
        .mem_to_reg(mem_to_reg), .alu_control(alu_control),
        .alu_immediate(alu_immediate), .rs(rs), .rt(rt), .use_rt(use_rt),
        .reg_dest(reg_dest), .qa(qa), .qb(qb), .immediate_32(immediate_32),
        .valid_execute(valid_execute), .write_reg_execute(write_reg_execute),
        .write_mem_execute(write_mem_execute),
        .mem_to_reg_execute(mem_to_reg_execute),
        .alu_immediate_execute(alu_immediate_execute),
        .alu_control_execute(alu_control_execute),
        .reg_dest_execute(reg_dest_execute), .qa_execute(qa_execute),
        .qb_execute(qb_execute), .immediate_32_execute(immediate_32_execute),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic wr, input logic wm, input logic m2r,
                          input logic [4:0] s, input logic [4:0] t, input logic ut,
                          input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        id_valid = v; write_reg = wr; write_mem = wm; mem_to_reg = m2r;
        rs = s; rt = t; use_rt = ut; reg_dest = rd; qa = a; qb = b;
    endtask

    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
        alu_control = 4'h0; alu_immediate = 1'b0; immediate_32 = 32'h0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", valid_execute, 0);
        check("rst_wreg", write_reg_execute, 0);
        check("rst_m2r", mem_to_reg_execute, 0);
        check("rst_qa", qa_execute, 0);
        check("rst_dest", reg_dest_execute, 0);
        check("rst_cnt", bubble_count, 0);
        check("rst_lus", load_use_stall, 0);

        // Normal capture
        alu_control = 4'h2;
        set_id(1, 1, 0, 0, 0, 0, 0, 5'd8, 32'h5, 32'h7);
        tick();
        check("norm_valid", valid_execute, 1);
        check("norm_dest", reg_dest_execute, 8);
        check("norm_qa", qa_execute, 32'h5);
        check("norm_qb", qb_execute, 32'h7);
        check("norm_aluc", alu_control_execute, 4'h2);
        check("norm_wreg", write_reg_execute, 1);

        // Load-use: lw r9 in EXE, consumer reads rs=9
        set_id(1, 1, 0, 1, 0, 0, 0, 5'd9, 32'h0, 32'h0);
        tick();
        check("lw_m2r", mem_to_reg_execute, 1);
        set_id(1, 1, 0, 0, 5'd9, 0, 0, 5'd10, 32'h11, 32'h0);
        #1 check("lu_stall", load_use_stall, 1);
        tick();
        check("lu_bub_valid", valid_execute, 0);
        check("lu_bub_wreg", write_reg_execute, 0);
        check("lu_cnt1", bubble_count, 1);
        check("lu_stall_drop", load_use_stall, 0);
        tick();
        check("lu_adv_valid", valid_execute, 1);
        check("lu_adv_dest", reg_dest_execute, 10);
        check("lu_adv_qa", qa_execute, 32'h11);
        check("lu_adv_cnt", bubble_count, 1);

        // Register 0 never hazards
        set_id(1, 1, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        set_id(1, 1, 0, 0, 5'd0, 5'd0, 1, 5'd4, 32'h0, 32'h0);
        #1 check("r0_nolus", load_use_stall, 0);

        // rt match only counts when use_rt
        set_id(1, 1, 0, 1, 5'd1, 5'd2, 0, 5'd9, 32'h0, 32'h0);
        tick();
        set_id(1, 1, 0, 0, 5'd3, 5'd9, 0, 5'd4, 32'h0, 32'h0);
        #1 check("rt_nouse", load_use_stall, 0);
        use_rt = 1'b1;
        #1 check("rt_use", load_use_stall, 1);
        id_valid = 1'b0;
        #1 check("rt_idinv", load_use_stall, 0);
        id_valid = 1'b1;

        // Flush beats stall and masks the hazard
        flush = 1'b1; stall_in = 1'b1;
        #1 check("fl_lus", load_use_stall, 0);
        tick();
        check("fl_valid", valid_execute, 0);
        check("fl_m2r", mem_to_reg_execute, 0);
        check("fl_cnt", bubble_count, 1);
        flush = 1'b0; stall_in = 1'b0;

        // Stall together with hazard: hold, no count
        set_id(1, 1, 0, 1, 5'd0, 5'd0, 0, 5'd9, 32'h0, 32'h0);
        tick();
        set_id(1, 1, 0, 0, 5'd9, 5'd0, 0, 5'd5, 32'h0, 32'h0);
        stall_in = 1'b1;
        #1 check("sh_lus", load_use_stall, 1);
        tick();
        check("sh_valid", valid_execute, 1);
        check("sh_m2r", mem_to_reg_execute, 1);
        check("sh_cnt", bubble_count, 1);
        check("sh_lus_held", load_use_stall, 1);
        stall_in = 1'b0;

        // Stall hold with changing inputs
        set_id(1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd3, 32'hDEAD_BEEF, 32'h0);
        tick();
        check("st_cap", qa_execute, 32'hDEAD_BEEF);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            qa = 32'h1234 + i; reg_dest = 5'(i + 20);
            tick();
            check("st_hold_qa", qa_execute, 32'hDEAD_BEEF);
            check("st_hold_dest", reg_dest_execute, 3);
        end
        check("st_cnt", bubble_count, 1);
        stall_in = 1'b0;
        tick();
        check("st_release", qa_execute, 32'h1236);

        // Non-valid slot captures fields but drops write enables
        set_id(0, 1, 1, 1, 5'd0, 5'd0, 0, 5'd7, 32'h0, 32'h77);
        alu_immediate = 1'b1; immediate_32 = 32'hFFFF_FFF0;
        tick();
        check("inv_valid", valid_execute, 0);
        check("inv_wreg", write_reg_execute, 0);
        check("inv_wmem", write_mem_execute, 0);
        check("inv_m2r", mem_to_reg_execute, 0);
        check("inv_qb", qb_execute, 32'h77);
        check("inv_dest", reg_dest_execute, 7);
        check("inv_imm", immediate_32_execute, 32'hFFFF_FFF0);
        check("inv_aluimm", alu_immediate_execute, 1);
        alu_immediate = 1'b0; immediate_32 = 32'h0;

        // Saturation with CNT_W=2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sat_rst", bubble_count, 0);
        for (int i = 0; i < 5; i++) begin
            set_id(1, 1, 0, 1, 5'd0, 5'd0, 0, 5'd9, 32'h0, 32'h0);
            tick();
            set_id(1, 1, 0, 0, 5'd9, 5'd0, 0, 5'd6, 32'h0, 32'h0);
            tick();
            check("sat_cnt", bubble_count, sat_exp[i]);
        end

        // Reset mid-hazard
        set_id(1, 1, 0, 1, 5'd0, 5'd0, 0, 5'd9, 32'h0, 32'h0);
        tick();
        set_id(1, 1, 0, 0, 5'd9, 5'd0, 0, 5'd6, 32'h0, 32'h0);
        #1 check("rm_lus_pre", load_use_stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_valid", valid_execute, 0);
        check("rm_lus", load_use_stall, 0);
        check("rm_cnt", bubble_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
